// File: rtl/nco_phase_acc_if.sv
// Control/phase bundle between the NCO phase accumulator and its driver.
// The slave side is the accumulator, which feeds the CORDIC phase input.
interface nco_phase_acc_if #(
  parameter int unsigned PHASE_W = 22
);
  logic                      en;
  logic signed [PHASE_W-1:0] fcw;
  logic                      fcw_load;
  logic signed [PHASE_W-1:0] phase_ofs;
  logic                      ofs_load;
  logic                      sync;
  logic signed [PHASE_W-1:0] phase;
  logic                      phase_vld;

  modport master (
    output en, fcw, fcw_load, phase_ofs, ofs_load, sync,
    input  phase, phase_vld
  );

  modport slave (
    input  en, fcw, fcw_load, phase_ofs, ofs_load, sync,
    output phase, phase_vld
  );
endinterface

// File: rtl/nco_phase_acc.sv
// Phase accumulator front end for the CORDIC NCO: integrate FCW, wrap to [-180,180), add offset.
// Optional phase dither (8-bit LFSR) is compiled in with `define NCO_DITHER_EN.
module nco_phase_acc #(
  parameter int unsigned PHASE_W   = 22,
  parameter int unsigned HALF_TURN = 1_800_000
) (
  input logic             clk,
  input logic             aresetn,
  nco_phase_acc_if.slave  bus
);
  localparam int unsigned SUM_W = PHASE_W + 1;
  localparam logic signed [SUM_W-1:0] HT   = SUM_W'(HALF_TURN);
  localparam logic signed [SUM_W-1:0] FULL = SUM_W'(2 * HALF_TURN);
  localparam logic signed [SUM_W-1:0] LIM  = SUM_W'(HALF_TURN - 1);

  // One correction suffices because every addend is clamped to within a half turn.
  function automatic logic signed [PHASE_W-1:0] f_wrap(input logic signed [SUM_W-1:0] s);
    logic signed [SUM_W-1:0] t;
    if (s >= HT)       t = s - FULL;
    else if (s < -HT)  t = s + FULL;
    else               t = s;
    return PHASE_W'(t);
  endfunction

  function automatic logic signed [PHASE_W-1:0] f_clamp(input logic signed [PHASE_W-1:0] v);
    logic signed [SUM_W-1:0] e;
    e = SUM_W'(v);
    if (e > LIM)        return PHASE_W'(LIM);
    else if (e < -LIM)  return PHASE_W'(-LIM);
    else                return v;
  endfunction

  logic signed [PHASE_W-1:0] r_fcw;
  logic signed [PHASE_W-1:0] r_ofs;
  logic signed [PHASE_W-1:0] r_acc;
  logic                      r_vld1;
  logic signed [PHASE_W-1:0] r_phase;
  logic                      r_phase_vld;

  logic signed [PHASE_W-1:0] w_acc_nxt;
  logic signed [SUM_W-1:0]   w_ph_sum;
  logic signed [PHASE_W-1:0] w_ph_nxt;

  assign w_acc_nxt = f_wrap(SUM_W'(r_acc) + SUM_W'(r_fcw));

`ifdef NCO_DITHER_EN
  logic [7:0]              r_lfsr;
  logic                    w_lfsr_fb;
  logic signed [SUM_W-1:0] w_dither;

  assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];
  assign w_dither  = SUM_W'($signed({1'b0, r_lfsr[3:0]})) - SUM_W'(8);
  assign w_ph_sum  = SUM_W'(r_acc) + SUM_W'(r_ofs) + w_dither;

  // Dither sequence advances once per emitted phase.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn)    r_lfsr <= 8'hA5;
    else if (r_vld1) r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
  end
`else
  assign w_ph_sum  = SUM_W'(r_acc) + SUM_W'(r_ofs);
`endif

  assign w_ph_nxt = f_wrap(w_ph_sum);

  // Control registers; new values are seen by the step after the load.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_fcw <= '0;
      r_ofs <= '0;
    end else begin
      if (bus.fcw_load) r_fcw <= f_clamp(bus.fcw);
      if (bus.ofs_load) r_ofs <= f_clamp(bus.phase_ofs);
    end
  end

  // Stage 1: accumulator, sync has priority over en.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_acc  <= '0;
      r_vld1 <= 1'b0;
    end else if (bus.sync) begin
      r_acc  <= '0;
      r_vld1 <= 1'b0;
    end else if (bus.en) begin
      r_acc  <= w_acc_nxt;
      r_vld1 <= 1'b1;
    end else begin
      r_vld1 <= 1'b0;
    end
  end

  // Stage 2: offset and output register; phase holds between valid cycles.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_phase     <= '0;
      r_phase_vld <= 1'b0;
    end else begin
      r_phase_vld <= r_vld1;
      if (r_vld1) r_phase <= w_ph_nxt;
    end
  end

  assign bus.phase     = r_phase;
  assign bus.phase_vld = r_phase_vld;
endmodule
